// File: rtl/data_mem_pkg.sv
// Shared constants, FSM encoding and lane helpers for the data_mem_lsu slice.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WS_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  function automatic logic [3:0] store_mask(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b0000;
    case (f3)
      F3_B:    m = 4'b0001 << off;
      F3_H:    m = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [31:0] word,
    input logic [1:0]  off,
    input logic [2:0]  f3
  );
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    r  = '0;
    case (f3)
      F3_B:    r = {{24{sh[7]}}, sh[7:0]};
      F3_H:    r = {{16{sh[15]}}, sh[15:0]};
      F3_W:    r = word;
      F3_BU:   r = {24'b0, sh[7:0]};
      F3_HU:   r = {16'b0, sh[15:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_lsu_load_align.sv
// Load alignment: selects the addressed byte/half and extends it per FUNCT3.
module load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  assign data_o = load_ext(word_i, off_i, funct3_i);

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed RV32 data RAM with MRd/MWrt-to-READY handshake and wait states.
// Define MISALIGN_EXC_EN to turn misaligned H/W accesses into ERR responses.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter  int DEPTH       = 256,
  parameter  int WAIT_STATES = 0,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MRd,
  input  logic        MWrt,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] W_DATA,
  output logic [31:0] R_DATA,
  output logic        READY,
  output logic        ERR
);

  localparam logic [WS_W-1:0] WS_LAST =
    (WAIT_STATES > 0) ? WS_W'(WAIT_STATES - 1) : '0;

  state_t          state_q, state_d;
  logic [WS_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic            bad_q, bad_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_q [DEPTH];

  logic            mem_we;
  logic [3:0]      be;
  logic [31:0]     wlane;
  logic [31:0]     ld_data;
  logic            f3_ok;
  logic            misal;
  logic            req_bad;
  logic [1:0]      off_in;
  logic            unused_addr;

  assign unused_addr = ^ADDR[31:AW+2];

  always_comb begin
    f3_ok  = FUNCT3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    off_in = ADDR[1:0];
    if (FUNCT3[1:0] == 2'b01) off_in[0] = 1'b0;
    else if (FUNCT3[1:0] == 2'b10) off_in = 2'b00;
    misal = 1'b0;
`ifdef MISALIGN_EXC_EN
    misal = (FUNCT3[1:0] == 2'b01 && ADDR[0]) ||
            (FUNCT3[1:0] == 2'b10 && ADDR[1:0] != 2'b00);
`endif
    req_bad = (MRd && MWrt) || !f3_ok || (MWrt && FUNCT3[2]) || misal;
  end

  always_comb begin
    be = store_mask(f3_q, off_q);
    case (f3_q[1:0])
      2'b00:   wlane = {4{wdata_q[7:0]}};
      2'b01:   wlane = {2{wdata_q[15:0]}};
      default: wlane = wdata_q;
    endcase
  end

  load_align u_align (
    .word_i   (mem_q[idx_q]),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    bad_d   = bad_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MRd || MWrt) begin
          idx_d   = ADDR[AW+1:2];
          off_d   = off_in;
          f3_d    = FUNCT3;
          wdata_d = W_DATA;
          wr_d    = MWrt;
          bad_d   = req_bad;
          cnt_d   = '0;
          state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WS_LAST) state_d = ACCESS;
      end
      ACCESS: begin
        ready_d = 1'b1;
        err_d   = bad_q;
        if (!bad_q) begin
          if (wr_q) mem_we = 1'b1;
          else rdata_d = ld_data;
        end
        state_d = DONE;
      end
      // Hold here until the requester lets go, so a held request cannot re-issue
      DONE: begin
        if (!MRd && !MWrt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      bad_q   <= bad_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[idx_q][8*b +: 8] <= wlane[8*b +: 8];
    end
  end

  assign R_DATA = rdata_q;
  assign READY  = ready_q;
  assign ERR    = err_q;

endmodule
